// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serial transmitter for the APB UART.
// Sends one asynchronous frame per rising edge of start_tx. The frame is a
// start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
//
// Ports:
//   pclk        - clock, rising edge
//   presetn     - asynchronous active-low reset
//   tx_data_in  - byte to send, captured at frame start
//   start_tx    - start control level; a rising edge requests a frame
//   cfg_in      - [1:0] data bits (5..8), [2] two stop bits,
//                 [3] parity enable, [4] even parity (1) / odd parity (0)
//   tx          - serial line, idles high
//   tx_busy     - high while a frame is in progress
//   tx_done     - high from the end of a frame until the next accepted request
module uart_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [7:0] tx_data_in,
    input  logic       start_tx,
    input  logic [4:0] cfg_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shadow_data;
    logic [4:0]       shadow_cfg;

    logic             request;
    logic             bit_end;
    logic [2:0]       last_data_idx;
    logic [2:0]       last_stop_idx;
    logic [7:0]       data_mask;
    logic             parity_bit;
    logic             tx_nxt;
    logic             tx_busy_nxt;
    logic             tx_done_nxt;

    // Rising edge of start_tx, accepted only while idle; anything else is dropped.
    assign request = start_tx & ~start_q & (state == S_IDLE);
    assign bit_end = (clk_cnt == CNT_MAX);

    // Data width 5..8 maps to last index 4..7.
    assign last_data_idx = {1'b1, shadow_cfg[1:0]};
    assign last_stop_idx = {2'b00, shadow_cfg[2]};

    // Parity covers only the bits actually sent; odd parity inverts the XOR.
    assign data_mask  = 8'hFF >> (2'd3 - shadow_cfg[1:0]);
    assign parity_bit = (^(shadow_data & data_mask)) ^ ~shadow_cfg[4];

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (request) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_idx == last_data_idx)) begin
                    state_nxt = shadow_cfg[3] ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP: begin
                if (bit_end && (bit_idx == last_stop_idx)) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; tx is computed from the upcoming state
    // so the registered line changes on the same edge as the state.
    always_comb begin
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        tx_nxt      = 1'b1;
        tx_busy_nxt = (state_nxt != S_IDLE);
        tx_done_nxt = tx_done;

        if ((state == S_IDLE) || bit_end) begin
            clk_cnt_nxt = '0;
        end else begin
            clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end

        // Bit index counts data bits in DATA and stop bits in STOP.
        if (state_nxt != state) begin
            bit_idx_nxt = 3'd0;
        end else if (bit_end && ((state == S_DATA) || (state == S_STOP))) begin
            bit_idx_nxt = bit_idx + 3'd1;
        end

        unique case (state_nxt)
            S_IDLE:   tx_nxt = 1'b1;
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shadow_data[bit_idx_nxt];
            S_PARITY: tx_nxt = parity_bit;
            S_STOP:   tx_nxt = 1'b1;
            default:  tx_nxt = 1'b1;
        endcase

        if (request) begin
            tx_done_nxt = 1'b0;
        end else if ((state == S_STOP) && (state_nxt == S_IDLE)) begin
            tx_done_nxt = 1'b1;
        end
    end

    // Registered outputs, counters, edge detector and frame shadow registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            start_q     <= 1'b0;
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            shadow_data <= 8'h00;
            shadow_cfg  <= 5'h00;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            start_q <= start_tx;
            clk_cnt <= clk_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            if (request) begin
                shadow_data <= tx_data_in;
                shadow_cfg  <= cfg_in;
            end
            tx      <= tx_nxt;
            tx_busy <= tx_busy_nxt;
            tx_done <= tx_done_nxt;
        end
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmitter for the APB UART. It consumes the transmit byte, start control and 5-bit frame configuration produced by the register block, and serialises one asynchronous frame on `tx`: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. It returns a done level that feeds the status register's TX-done bit.

## Interface
- `CLKS_PER_BIT`, default 16: pclk cycles per serial bit; legal values are ≥ 2.
- `pclk` input, 1 bit: clock, rising edge.
- `presetn` input, 1 bit: reset, asynchronous, active-low.
- `tx_data_in` input, 8 bits: byte to send; sampled only at frame start.
- `start_tx` input, 1 bit: start control level; its rising edge requests a frame.
- `cfg_in` input, 5 bits: frame configuration, sampled only at frame start. `[1:0]` sets data bits (00=5, 01=6, 10=7, 11=8). `[2]` sets stop bits (0=1, 1=2). `[3]` is parity enable. `[4]` selects parity type (1=even, 0=odd).
- `tx` output, 1 bit: serial line; idles high.
- `tx_busy` output, 1 bit: high while a frame is in progress.
- `tx_done` output, 1 bit: high from the end of a frame until the next frame starts.

## Operation
- Edge detection: `start_q` registers `start_tx`. A request is `start_tx & ~start_q` while the state is IDLE.
  - A request arriving in any other state is dropped and is not queued.
  - A level held high never retriggers.
- Frame capture: when a request is accepted, `tx_data_in` and `cfg_in` are latched into shadow registers. Input changes during the frame have no effect.
- Data masking: data bits above the configured width are ignored.
- Parity: XOR of the N transmitted data bits. Even parity sends that XOR; odd parity sends its inverse.
- State machine:
  - IDLE → START on request. `tx`=0, `tx_busy`=1, `tx_done`=0.
  - START → DATA after one bit period. Bit index = 0.
  - DATA → shifts LSB first, one bit per period. After bit N−1 it goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY → STOP after one bit period.
  - STOP → `tx`=1 for 1 or 2 bit periods, then → IDLE. `tx_busy`=0, `tx_done`=1.
- Bit timing: a counter runs 0..CLKS_PER_BIT−1 in every non-IDLE state. The state or bit advances when the counter reaches CLKS_PER_BIT−1, and the counter then wraps to 0.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, `start_q`=0, all counters and shadow registers 0.
- Reset mid-frame aborts the frame immediately. `tx` returns high asynchronously and no done is reported.

## Timing
- `start_tx` first sampled high at edge k, with `start_q`=0 and state IDLE: `tx` falls and `tx_busy` rises at edge k (registered outputs, visible after k).
- Each bit occupies exactly CLKS_PER_BIT cycles.
- Frame length is (1 + N + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- `tx_done` rises and `tx_busy` falls on the same edge that ends the last stop bit. `tx_done` stays high until the next accepted request.
- Back-to-back frames: a request is honoured one cycle after return to IDLE at the earliest. The minimum gap between frames is 0 idle bit periods plus 1 cycle.
- Simultaneous events: a start edge on the same edge that ends the stop bit is ignored, because the state was not IDLE when sampled.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **8N1 frame**: reset, CLKS_PER_BIT=4, cfg=5'b00011, data=0xA5, pulse `start_tx`. Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total. `tx_done`=1 and `tx_busy`=0 afterwards.
- **Parity**: data=0xA5, cfg=5'b11011 (8E1) → parity bit 0. cfg=5'b01011 (8O1) → parity bit 1. Frame is 44 cycles.
- **5-bit, 2 stop, even parity**: cfg=5'b11100, data=0xFF → data bits 1,1,1,1,1, parity 1, then two stop bits. Bits 5–7 are not sent. Frame is 36 cycles.
- **Retrigger rules**: hold `start_tx` high through the whole frame → exactly one frame. Change `tx_data_in` and `cfg_in` mid-frame → frame is unchanged. Toggle `start_tx` mid-frame → no second frame.
- **Reset mid-frame**: assert `presetn` low during DATA → `tx`=1, `tx_busy`=0, `tx_done`=0 immediately. After release, a new request sends a clean frame.
- **Back-to-back**: re-raise `start_tx` one cycle after `tx_done` rises → second frame starts and `tx_done` clears on that edge.
